// File: rtl/cntx_pool_if.sv
// Context-pool bus: decode/branch, update, resolution, retire, fetch and squash signals.
interface cntx_pool_if #(
  parameter int unsigned N_CNTX = 8,
  parameter int unsigned W_PC   = 32
);
  localparam int unsigned W_CNT = $clog2(N_CNTX + 1);

  logic              dec_branch;
  logic [N_CNTX-1:0] dec_context;
  logic [W_PC-1:0]   dec_pc_t;
  logic [W_PC-1:0]   dec_pc_f;
  logic              alloc_ok;
  logic [N_CNTX-1:0] alloc_t;
  logic [N_CNTX-1:0] alloc_f;
  logic              upd_valid;
  logic [N_CNTX-1:0] upd_context;
  logic [W_PC-1:0]   upd_pc;
  logic              res_valid;
  logic [N_CNTX-1:0] res_keep;
  logic [N_CNTX-1:0] res_kill;
  logic              ret_valid;
  logic [N_CNTX-1:0] ret_context;
  logic              fetch_valid;
  logic              fetch_ready;
  logic [N_CNTX-1:0] fetch_context;
  logic [W_PC-1:0]   fetch_pc;
  logic              hazard;
  logic [N_CNTX-1:0] hazard_mask;
  logic [W_CNT-1:0]  free_count;

  modport master (
    output dec_branch, dec_context, dec_pc_t, dec_pc_f,
    output upd_valid, upd_context, upd_pc,
    output res_valid, res_keep, res_kill,
    output ret_valid, ret_context, fetch_ready,
    input  alloc_ok, alloc_t, alloc_f, fetch_valid, fetch_context, fetch_pc,
    input  hazard, hazard_mask, free_count
  );

  modport slave (
    input  dec_branch, dec_context, dec_pc_t, dec_pc_f,
    input  upd_valid, upd_context, upd_pc,
    input  res_valid, res_keep, res_kill,
    input  ret_valid, ret_context, fetch_ready,
    output alloc_ok, alloc_t, alloc_f, fetch_valid, fetch_context, fetch_pc,
    output hazard, hazard_mask, free_count
  );
endinterface

// File: rtl/cntx_pool.sv
// Speculative fetch context pool: bitmap allocation, ancestry-based subtree squash,
// retire, and a registered fetch request for the hot context.
module cntx_pool #(
  parameter int unsigned      N_CNTX   = 8,
  parameter int unsigned      W_PC     = 32,
  parameter logic [W_PC-1:0]  RESET_PC = '0
) (
  input  logic        clk,
  input  logic        rstn,
  cntx_pool_if.slave  bus
);
  localparam int unsigned W_CNT = $clog2(N_CNTX + 1);

  logic [N_CNTX-1:0]             live_q, live_d;
  logic [N_CNTX-1:0]             pending_q, pending_d;
  logic [N_CNTX-1:0]             hot_q, hot_d;
  logic [N_CNTX-1:0][W_PC-1:0]   pc_q, pc_d;
  logic [N_CNTX-1:0][N_CNTX-1:0] anc_q, anc_d;
  logic                          hazard_q, hazard_d;
  logic [N_CNTX-1:0]             hazard_mask_q, hazard_mask_d;

  logic [N_CNTX-1:0] alloc_t, alloc_f, kill, parent_anc;
  logic              found_t, found_f;
  logic [W_CNT-1:0]  free_cnt;
  logic [W_PC-1:0]   hot_pc;
  logic              alloc_ok, fetch_valid, fetch_acc, branch_acc, upd_acc;

  // Lowest and next-lowest free contexts, plus the free population, from registered state.
  always_comb begin
    alloc_t  = '0;
    alloc_f  = '0;
    found_t  = 1'b0;
    found_f  = 1'b0;
    free_cnt = '0;
    for (int unsigned c = 0; c < N_CNTX; c++) begin
      if (!live_q[c]) begin
        free_cnt = free_cnt + W_CNT'(1);
        if (!found_t) begin
          alloc_t[c] = 1'b1;
          found_t    = 1'b1;
        end else if (!found_f) begin
          alloc_f[c] = 1'b1;
          found_f    = 1'b1;
        end
      end
    end
  end

  // Hot-context PC select, branch parent ancestry, and the squash set (loser plus descendants).
  always_comb begin
    hot_pc     = '0;
    parent_anc = '0;
    kill       = '0;
    for (int unsigned c = 0; c < N_CNTX; c++) begin
      if (hot_q[c])           hot_pc     = hot_pc | pc_q[c];
      if (bus.dec_context[c]) parent_anc = parent_anc | anc_q[c];
      kill[c] = bus.res_valid & live_q[c] & (|(anc_q[c] & bus.res_kill));
    end
  end

  assign alloc_ok    = (free_cnt >= W_CNT'(2));
  assign fetch_valid = |(pending_q & hot_q);
  assign fetch_acc   = fetch_valid & bus.fetch_ready;
  assign branch_acc  = bus.dec_branch & alloc_ok & ~(|(bus.dec_context & kill));
  assign upd_acc     = bus.upd_valid & (|(bus.upd_context & live_q & ~kill));

  assign bus.alloc_ok      = alloc_ok;
  assign bus.alloc_t       = alloc_t;
  assign bus.alloc_f       = alloc_f;
  assign bus.free_count    = free_cnt;
  assign bus.fetch_valid   = fetch_valid;
  assign bus.fetch_context = hot_q;
  assign bus.fetch_pc      = hot_pc;
  assign bus.hazard        = hazard_q;
  assign bus.hazard_mask   = hazard_mask_q;

  // Next state: events applied lowest priority first so higher-priority ones overwrite.
  always_comb begin
    live_d        = live_q;
    pending_d     = pending_q;
    pc_d          = pc_q;
    anc_d         = anc_q;
    hot_d         = hot_q;
    hazard_d      = bus.res_valid;
    hazard_mask_d = kill;

    if (fetch_acc) pending_d = pending_q & ~hot_q;

    for (int unsigned c = 0; c < N_CNTX; c++) begin
      if (upd_acc && bus.upd_context[c]) begin
        pc_d[c]      = bus.upd_pc;
        pending_d[c] = 1'b1;
      end
      if (branch_acc && alloc_t[c]) begin
        live_d[c]    = 1'b1;
        pending_d[c] = 1'b1;
        pc_d[c]      = bus.dec_pc_t;
        anc_d[c]     = parent_anc | alloc_t;
      end
      if (branch_acc && alloc_f[c]) begin
        live_d[c]    = 1'b1;
        pending_d[c] = 1'b1;
        pc_d[c]      = bus.dec_pc_f;
        anc_d[c]     = parent_anc | alloc_f;
      end
    end
    if (branch_acc) hot_d = alloc_t;

    // Retire clears the bit everywhere, including ancestry just built for new children.
    if (bus.ret_valid) begin
      for (int unsigned c = 0; c < N_CNTX; c++) begin
        anc_d[c] = anc_d[c] & ~bus.ret_context;
        if (bus.ret_context[c]) begin
          live_d[c]    = 1'b0;
          pending_d[c] = 1'b0;
          anc_d[c]     = '0;
        end
      end
    end

    for (int unsigned c = 0; c < N_CNTX; c++) begin
      if (kill[c]) begin
        live_d[c]    = 1'b0;
        pending_d[c] = 1'b0;
        anc_d[c]     = '0;
      end
    end
    if (|(hot_q & kill)) hot_d = bus.res_keep;
  end

  // State registers; reset leaves only context 0 live and fetching RESET_PC.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      live_q        <= N_CNTX'(1);
      pending_q     <= N_CNTX'(1);
      hot_q         <= N_CNTX'(1);
      pc_q          <= '0;
      pc_q[0]       <= RESET_PC;
      anc_q         <= '0;
      anc_q[0]      <= N_CNTX'(1);
      hazard_q      <= 1'b0;
      hazard_mask_q <= '0;
    end else begin
      live_q        <= live_d;
      pending_q     <= pending_d;
      hot_q         <= hot_d;
      pc_q          <= pc_d;
      anc_q         <= anc_d;
      hazard_q      <= hazard_d;
      hazard_mask_q <= hazard_mask_d;
    end
  end
endmodule

// File: tb/tb_cntx_pool.sv
// Testbench for cntx_pool: directed scenarios followed by random traffic against a context model.
module tb_cntx_pool;
  localparam int unsigned N   = 8;
  localparam int unsigned W   = 32;
  localparam logic [W-1:0] RPC = 32'h0000_0080;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad   = 0;

  cntx_pool_if #(.N_CNTX(N), .W_PC(W)) bus ();
  cntx_pool #(.N_CNTX(N), .W_PC(W), .RESET_PC(RPC)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  // Context model: per-context flags, PC and ancestor set; hot kept as an index.
  bit           m_live[N];
  bit           m_pend[N];
  logic [W-1:0] m_pc[N];
  logic [N-1:0] m_anc[N];
  int           m_hot;
  bit           m_haz;
  logic [N-1:0] m_hmask;
  int           pa[$];
  int           pb[$];

  function automatic int idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  function automatic int nth_free(input int k);
    int seen = 0;
    for (int i = 0; i < N; i++)
      if (!m_live[i]) begin
        if (seen == k) return i;
        seen++;
      end
    return -1;
  endfunction

  function automatic int free_cnt();
    int n = 0;
    for (int i = 0; i < N; i++) if (!m_live[i]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_live[i] = 1'b0; m_pend[i] = 1'b0; m_pc[i] = '0; m_anc[i] = '0;
    end
    m_live[0] = 1'b1; m_pend[0] = 1'b1; m_pc[0] = RPC; m_anc[0] = 8'h01;
    m_hot = 0; m_haz = 1'b0; m_hmask = '0;
    pa.delete(); pb.delete();
  endtask

  task automatic model_step();
    bit nl[N]; bit np[N]; logic [W-1:0] npc[N]; logic [N-1:0] na[N];
    logic [N-1:0] kset = '0;
    logic [N-1:0] pan;
    int r = -1, p = -1, u = -1, t = -1, f = -1;
    bit br = 1'b0, upd = 1'b0;
    nl = m_live; np = m_pend; npc = m_pc; na = m_anc;
    if (bus.res_valid)
      for (int c = 0; c < N; c++) if (m_live[c] && (m_anc[c] & bus.res_kill) != '0) kset[c] = 1'b1;
    for (int c = 0; c < N; c++) if (kset[c]) begin nl[c] = 0; np[c] = 0; na[c] = '0; end
    if (bus.ret_valid) begin
      r = idx(bus.ret_context);
      nl[r] = 0; np[r] = 0; na[r] = '0;
      for (int c = 0; c < N; c++) na[c][r] = 1'b0;
    end
    if (bus.dec_branch) begin
      p  = idx(bus.dec_context);
      br = (free_cnt() >= 2) && !kset[p];
    end
    if (br) begin
      t = nth_free(0); f = nth_free(1);
      pan = m_anc[p];
      if (r >= 0) pan[r] = 1'b0;
      nl[t] = 1; np[t] = 1; npc[t] = bus.dec_pc_t; na[t] = pan | oh(t);
      nl[f] = 1; np[f] = 1; npc[f] = bus.dec_pc_f; na[f] = pan | oh(f);
    end
    if (bus.upd_valid) begin
      u = idx(bus.upd_context);
      if (m_live[u] && !kset[u] && u != r) begin
        npc[u] = bus.upd_pc; np[u] = 1; upd = 1'b1;
      end
    end
    if (m_pend[m_hot] && bus.fetch_ready && !(upd && u == m_hot) && !kset[m_hot]) np[m_hot] = 0;
    if (kset[m_hot]) m_hot = idx(bus.res_keep);
    else if (br) m_hot = t;
    m_haz = bus.res_valid; m_hmask = kset;
    m_live = nl; m_pend = np; m_pc = npc; m_anc = na;
    for (int i = pa.size() - 1; i >= 0; i--)
      if (!m_live[pa[i]] || !m_live[pb[i]]) begin pa.delete(i); pb.delete(i); end
    if (br) begin pa.push_back(t); pb.push_back(f); end
  endtask

  task automatic idle_inputs();
    bus.dec_branch = 0; bus.dec_context = '0; bus.dec_pc_t = '0; bus.dec_pc_f = '0;
    bus.upd_valid = 0; bus.upd_context = '0; bus.upd_pc = '0;
    bus.res_valid = 0; bus.res_keep = '0; bus.res_kill = '0;
    bus.ret_valid = 0; bus.ret_context = '0;
  endtask

  task automatic tick();
    if (bus.res_valid) assert ($onehot(bus.res_kill) && m_live[idx(bus.res_kill)]) else $error("illegal res_kill");
    if (bus.ret_valid) assert ($onehot(bus.ret_context) && idx(bus.ret_context) != m_hot) else $error("illegal ret_context");
    if (bus.dec_branch) assert ($onehot(bus.dec_context)) else $error("illegal dec_context");
    if (bus.upd_valid) assert ($onehot(bus.upd_context)) else $error("illegal upd_context");
    @(posedge clk);
    if (rstn) model_step(); else model_reset();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs(); bus.fetch_ready = 1; rstn = 0;
    repeat (2) @(negedge clk);
    model_reset();
    total++; if (bus.free_count !== 4'd7) begin bad++; $display("FAIL rst_free got=%0d exp=7", bus.free_count); end
    total++; if (bus.hazard !== 1'b0) begin bad++; $display("FAIL rst_hazard got=%b exp=0", bus.hazard); end
    rstn = 1;
    total++; if (bus.fetch_valid !== 1'b1) begin bad++; $display("FAIL c0_fv got=%b exp=1", bus.fetch_valid); end
    total++; if (bus.fetch_context !== 8'h01) begin bad++; $display("FAIL c0_ctx got=%h exp=01", bus.fetch_context); end
    total++; if (bus.fetch_pc !== RPC) begin bad++; $display("FAIL c0_pc got=%h exp=%h", bus.fetch_pc, RPC); end
    total++; if (bus.alloc_ok !== 1'b1) begin bad++; $display("FAIL c0_aok got=%b exp=1", bus.alloc_ok); end
    tick();
    total++; if (bus.fetch_valid !== 1'b0) begin bad++; $display("FAIL c1_fv got=%b exp=0", bus.fetch_valid); end
  endtask

  task automatic test_branch();
    bus.dec_branch = 1; bus.dec_context = 8'h01; bus.dec_pc_t = 32'h100; bus.dec_pc_f = 32'h104;
    total++; if (bus.alloc_t !== 8'h02) begin bad++; $display("FAIL br_at got=%h exp=02", bus.alloc_t); end
    total++; if (bus.alloc_f !== 8'h04) begin bad++; $display("FAIL br_af got=%h exp=04", bus.alloc_f); end
    tick();
    total++; if (bus.fetch_context !== 8'h02) begin bad++; $display("FAIL br_ctx got=%h exp=02", bus.fetch_context); end
    total++; if (bus.fetch_pc !== 32'h100) begin bad++; $display("FAIL br_pc got=%h exp=100", bus.fetch_pc); end
    total++; if (bus.fetch_valid !== 1'b1) begin bad++; $display("FAIL br_fv got=%b exp=1", bus.fetch_valid); end
    total++; if (bus.free_count !== 4'd5) begin bad++; $display("FAIL br_free got=%0d exp=5", bus.free_count); end
  endtask

  task automatic test_subtree_kill();
    bus.dec_branch = 1; bus.dec_context = 8'h02; bus.dec_pc_t = 32'h200; bus.dec_pc_f = 32'h204;
    total++; if (bus.alloc_t !== 8'h08 || bus.alloc_f !== 8'h10) begin bad++; $display("FAIL nest_alloc got=%h/%h exp=08/10", bus.alloc_t, bus.alloc_f); end
    tick();
    total++; if (bus.fetch_context !== 8'h08 || bus.free_count !== 4'd3) begin bad++; $display("FAIL nest_state got=%h/%0d exp=08/3", bus.fetch_context, bus.free_count); end
    bus.res_valid = 1; bus.res_keep = 8'h04; bus.res_kill = 8'h02;
    tick();
    total++; if (bus.hazard !== 1'b1) begin bad++; $display("FAIL kill_haz got=%b exp=1", bus.hazard); end
    total++; if (bus.hazard_mask !== 8'h1A) begin bad++; $display("FAIL kill_mask got=%h exp=1a", bus.hazard_mask); end
    total++; if (bus.fetch_context !== 8'h04 || bus.fetch_pc !== 32'h104) begin bad++; $display("FAIL kill_redir got=%h/%h exp=04/104", bus.fetch_context, bus.fetch_pc); end
    total++; if (bus.fetch_valid !== 1'b1) begin bad++; $display("FAIL kill_fv got=%b exp=1", bus.fetch_valid); end
    tick();
    total++; if (bus.hazard !== 1'b0 || bus.free_count !== 4'd6) begin bad++; $display("FAIL kill_after got=%b/%0d exp=0/6", bus.hazard, bus.free_count); end
  endtask

  task automatic test_exhaustion();
    logic [N-1:0] par [3] = '{8'h04, 8'h01, 8'h08};
    bus.ret_valid = 1; bus.ret_context = 8'h01;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.dec_branch = 1; bus.dec_context = par[i];
      bus.dec_pc_t = 32'h500 + 32'(i * 16); bus.dec_pc_f = 32'h508 + 32'(i * 16);
      tick();
    end
    total++; if (bus.free_count !== 4'd1 || bus.alloc_ok !== 1'b0) begin bad++; $display("FAIL exh_state got=%0d/%b exp=1/0", bus.free_count, bus.alloc_ok); end
    bus.dec_branch = 1; bus.dec_context = 8'h20; bus.dec_pc_t = 32'h900; bus.dec_pc_f = 32'h904;
    tick();
    total++; if (bus.free_count !== 4'd1 || bus.fetch_context !== 8'h20) begin bad++; $display("FAIL exh_ignore got=%0d/%h exp=1/20", bus.free_count, bus.fetch_context); end
    bus.ret_valid = 1; bus.ret_context = 8'h04;
    tick();
    total++; if (bus.alloc_ok !== 1'b1 || bus.free_count !== 4'd2) begin bad++; $display("FAIL exh_restore got=%b/%0d exp=1/2", bus.alloc_ok, bus.free_count); end
    total++; if (bus.alloc_t !== 8'h04 || bus.alloc_f !== 8'h80) begin bad++; $display("FAIL exh_alloc got=%h/%h exp=04/80", bus.alloc_t, bus.alloc_f); end
  endtask

  task automatic test_collision();
    bus.dec_branch = 1; bus.dec_context = 8'h20; bus.dec_pc_t = 32'h400; bus.dec_pc_f = 32'h404;
    tick();
    bus.res_valid = 1; bus.res_keep = 8'h80; bus.res_kill = 8'h04;
    bus.upd_valid = 1; bus.upd_context = 8'h04; bus.upd_pc = 32'h300;
    tick();
    total++; if (bus.hazard_mask !== 8'h04 || bus.free_count !== 4'd1) begin bad++; $display("FAIL col_free got=%h/%0d exp=04/1", bus.hazard_mask, bus.free_count); end
    total++; if (bus.fetch_context !== 8'h80 || bus.fetch_pc !== 32'h404) begin bad++; $display("FAIL col_redir got=%h/%h exp=80/404", bus.fetch_context, bus.fetch_pc); end
    total++; if (bus.alloc_t !== 8'h04) begin bad++; $display("FAIL col_alloc got=%h exp=04", bus.alloc_t); end
  endtask

  task automatic test_upd_accept();
    bus.fetch_ready = 1; bus.upd_valid = 1; bus.upd_context = 8'h80; bus.upd_pc = 32'h200;
    tick();
    total++; if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== 32'h200) begin bad++; $display("FAIL ua_fetch got=%b/%h exp=1/200", bus.fetch_valid, bus.fetch_pc); end
    tick();
    total++; if (bus.fetch_valid !== 1'b0) begin bad++; $display("FAIL ua_drain got=%b exp=0", bus.fetch_valid); end
  endtask

  task automatic test_mid_reset();
    bus.res_valid = 1; bus.res_keep = 8'h40; bus.res_kill = 8'h20;
    tick();
    total++; if (bus.hazard_mask !== 8'hA0 || bus.fetch_context !== 8'h40 || bus.fetch_pc !== 32'h528) begin
      bad++; $display("FAIL mr_kill got=%h/%h/%h exp=a0/40/528", bus.hazard_mask, bus.fetch_context, bus.fetch_pc); end
    total++; if (bus.free_count !== 4'd3) begin bad++; $display("FAIL mr_free got=%0d exp=3", bus.free_count); end
    rstn = 0;
    #1;
    total++; if (bus.hazard !== 1'b0 || bus.hazard_mask !== 8'h00) begin bad++; $display("FAIL mr_haz got=%b/%h exp=0/00", bus.hazard, bus.hazard_mask); end
    total++; if (bus.fetch_context !== 8'h01 || bus.fetch_pc !== RPC || bus.fetch_valid !== 1'b1 || bus.free_count !== 4'd7) begin
      bad++; $display("FAIL mr_state got=%h/%h/%b/%0d exp=01/%h/1/7", bus.fetch_context, bus.fetch_pc, bus.fetch_valid, bus.free_count, RPC); end
    model_reset();
    @(negedge clk);
    rstn = 1;
  endtask

  task automatic test_random(input int cycles);
    int q[$];
    int u, k, keep, kill, r;
    for (int n = 0; n < cycles; n++) begin
      total++; if (bus.fetch_valid !== m_pend[m_hot] || bus.fetch_context !== oh(m_hot) || bus.fetch_pc !== m_pc[m_hot]) begin
        bad++; $display("FAIL rnd_fetch cyc=%0d got=%b/%h/%h exp=%b/%h/%h", n, bus.fetch_valid, bus.fetch_context, bus.fetch_pc, m_pend[m_hot], oh(m_hot), m_pc[m_hot]); end
      total++; if (bus.free_count !== 4'(free_cnt()) || bus.alloc_ok !== (free_cnt() >= 2)) begin
        bad++; $display("FAIL rnd_free cyc=%0d got=%0d/%b exp=%0d", n, bus.free_count, bus.alloc_ok, free_cnt()); end
      total++; if (bus.alloc_t !== oh(nth_free(0)) || bus.alloc_f !== oh(nth_free(1))) begin
        bad++; $display("FAIL rnd_alloc cyc=%0d got=%h/%h exp=%h/%h", n, bus.alloc_t, bus.alloc_f, oh(nth_free(0)), oh(nth_free(1))); end
      total++; if (bus.hazard !== m_haz || bus.hazard_mask !== m_hmask) begin
        bad++; $display("FAIL rnd_hazard cyc=%0d got=%b/%h exp=%b/%h", n, bus.hazard, bus.hazard_mask, m_haz, m_hmask); end
      bus.fetch_ready = ($urandom_range(0, 3) != 0);
      q.delete();
      for (int i = 0; i < N; i++) if (m_live[i]) q.push_back(i);
      if ($urandom_range(0, 2) == 0) begin
        bus.dec_branch = 1; bus.dec_context = oh(m_hot);
        bus.dec_pc_t = 32'($urandom) & 32'hFFFF_FFFC; bus.dec_pc_f = 32'($urandom) & 32'hFFFF_FFFC;
      end
      u = -1;
      if ($urandom_range(0, 3) == 0) begin
        u = q[$urandom_range(0, q.size() - 1)];
        bus.upd_valid = 1; bus.upd_context = oh(u); bus.upd_pc = 32'($urandom) & 32'hFFFF_FFFC;
      end
      keep = -1;
      if (pa.size() > 0 && $urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, pa.size() - 1);
        if ($urandom_range(0, 1) == 1) begin keep = pa[k]; kill = pb[k]; end
        else begin keep = pb[k]; kill = pa[k]; end
        bus.res_valid = 1; bus.res_keep = oh(keep); bus.res_kill = oh(kill);
      end
      if ($urandom_range(0, 2) == 0) begin
        r = q[$urandom_range(0, q.size() - 1)];
        if (r != m_hot && r != keep && r != u) begin
          bus.ret_valid = 1; bus.ret_context = oh(r);
        end
      end
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    bus.fetch_ready = 0;
    test_reset();
    test_branch();
    test_subtree_kill();
    test_exhaustion();
    test_collision();
    test_upd_accept();
    test_mid_reset();
    test_random(1500);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
